// File: rtl/rupt_priority_controller.sv
// Interrupt priority controller: edge-latched pending requests, fixed-priority grant
// at instruction boundaries, single-level service with a rupt-lock watchdog alarm.
module rupt_priority_controller #(
  parameter int unsigned LOCK_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  rupt_req,
  input  logic        inst_boundary,
  input  logic        inhint,
  input  logic        extend_pending,
  input  logic        resume,
  output logic        rupt_take,
  output logic [11:0] rupt_vector,
  output logic [3:0]  rupt_index,
  output logic        in_service,
  output logic [9:0]  pending,
  output logic        rupt_lock_alarm
);

  localparam int unsigned NREQ   = 10;
  localparam int unsigned VEC_W  = 12;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LOCK_W = 16;

  localparam logic [VEC_W-1:0]  VEC_BASE = 12'o4004;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    req_q, req_d;
  logic               armed_q, armed_d;
  logic [NREQ-1:0]    pending_q, pending_d;
  logic               take_q, take_d;
  logic               in_service_q, in_service_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic               alarm_q, alarm_d;

  logic [NREQ-1:0]    rise_c;
  logic [NREQ-1:0]    clr_mask_c;
  logic               grant_ok_c;

  // Lowest set bit wins: bit 0 is the highest-priority request.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NREQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // armed_q suppresses edge detection on the first cycle after reset, so a
  // request already high at release is not mistaken for a new edge.
  always_comb begin
    state_d      = state_q;
    req_d        = rupt_req;
    armed_d      = 1'b1;
    pending_d    = pending_q;
    take_d       = 1'b0;
    in_service_d = 1'b0;
    index_d      = index_q;
    vector_d     = vector_q;
    lock_d       = lock_q;
    alarm_d      = alarm_q;

    rise_c     = armed_q ? (rupt_req & ~req_q) : '0;
    clr_mask_c = NREQ'(1) << index_q;
    grant_ok_c = inst_boundary & ~inhint & ~extend_pending & (|pending_q);

    case (state_q)
      IDLE: begin
        if (grant_ok_c) begin
          state_d  = TAKE;
          take_d   = 1'b1;
          index_d  = lowest_set(pending_q);
          vector_d = VEC_BASE + VEC_W'({index_d, 2'b00});
        end
      end
      TAKE: begin
        pending_d    = pending_q & ~clr_mask_c;
        state_d      = SERVICE;
        in_service_d = 1'b1;
        lock_d       = '0;
      end
      SERVICE: begin
        in_service_d = 1'b1;
        if (lock_q < LOCK_MAX) lock_d = lock_q + LOCK_W'(1);
        if (lock_d == LOCK_MAX) alarm_d = 1'b1;
        if (resume) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh edge overrides the clear issued in TAKE.
    pending_d = pending_d | rise_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      armed_q      <= 1'b0;
      pending_q    <= '0;
      take_q       <= 1'b0;
      in_service_q <= 1'b0;
      index_q      <= '0;
      vector_q     <= VEC_BASE;
      lock_q       <= '0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      take_q       <= take_d;
      in_service_q <= in_service_d;
      index_q      <= index_d;
      vector_q     <= vector_d;
      lock_q       <= lock_d;
      alarm_q      <= alarm_d;
    end
  end

  assign rupt_take       = take_q;
  assign rupt_vector     = vector_q;
  assign rupt_index      = index_q;
  assign in_service      = in_service_q;
  assign pending         = pending_q;
  assign rupt_lock_alarm = alarm_q;

endmodule

// File: tb/tb_rupt_priority_controller.sv
// Scoreboard bench for rupt_priority_controller: a cycle-level reference model predicts
// grants and status; a negedge monitor checks the DUT against it.
module tb_rupt_priority_controller;

  localparam int unsigned LIMIT = 8;
  localparam int VBASE = 'o4004;
  localparam int PH_IDLE = 0, PH_TAKE = 1, PH_SVC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rupt_req;
  logic        inst_boundary, inhint, extend_pending, resume;
  logic        rupt_take;
  logic [11:0] rupt_vector;
  logic [3:0]  rupt_index;
  logic        in_service;
  logic [9:0]  pending;
  logic        rupt_lock_alarm;

  rupt_priority_controller #(.LOCK_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .rupt_req       (rupt_req),
    .inst_boundary  (inst_boundary),
    .inhint         (inhint),
    .extend_pending (extend_pending),
    .resume         (resume),
    .rupt_take      (rupt_take),
    .rupt_vector    (rupt_vector),
    .rupt_index     (rupt_index),
    .in_service     (in_service),
    .pending        (pending),
    .rupt_lock_alarm(rupt_lock_alarm)
  );

  always #5 clk = ~clk;

  // Reference model state
  int        m_phase = PH_IDLE;
  bit [9:0]  m_pend = '0;
  bit [9:0]  m_prev = '0;
  bit        m_armed = 1'b0;
  int        m_idx = 0;
  int        m_svc_cycles = 0;
  bit        m_alarm = 1'b0;
  int        last_idx = 0;
  int        exp_q[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Predicts the effect of one clock edge given the inputs driven for it.
  task automatic model_step(input bit rst, input bit [9:0] req, input bit ib,
                            input bit inh, input bit ext, input bit res);
    bit [9:0] rises;
    if (rst) begin
      m_phase = PH_IDLE; m_pend = '0; m_prev = '0; m_armed = 1'b0;
      m_svc_cycles = 0; m_alarm = 1'b0; last_idx = 0; m_idx = 0;
      exp_q.delete();
      return;
    end
    rises = m_armed ? (req & ~m_prev) : 10'd0;
    case (m_phase)
      PH_IDLE: if (ib && !inh && !ext && m_pend != 0) begin
        m_idx = -1;
        for (int i = 0; i < 10; i++) if (m_pend[i] && m_idx < 0) m_idx = i;
        exp_q.push_back(m_idx);
        last_idx = m_idx;
        m_phase = PH_TAKE;
      end
      PH_TAKE: begin
        m_pend[m_idx] = 1'b0;
        m_svc_cycles = 0;
        m_phase = PH_SVC;
      end
      default: begin
        if (m_svc_cycles < int'(LIMIT)) m_svc_cycles++;
        if (m_svc_cycles == int'(LIMIT)) m_alarm = 1'b1;
        if (res) m_phase = PH_IDLE;
      end
    endcase
    m_pend = m_pend | rises;
    m_prev = req;
    m_armed = 1'b1;
  endtask

  task automatic cyc(input bit rst, input bit [9:0] req, input bit ib,
                     input bit inh, input bit ext, input bit res);
    @(negedge clk);
    #1;
    reset = rst; rupt_req = req; inst_boundary = ib;
    inhint = inh; extend_pending = ext; resume = res;
    model_step(rst, req, ib, inh, ext, res);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_resume();
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every rupt_take and checks status every cycle.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      chk("rupt_take", int'(rupt_take), int'(m_phase == PH_TAKE));
      if (rupt_take) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_index", int'(rupt_index), e);
          chk("grant_vector", int'(rupt_vector), VBASE + 4 * e);
        end
      end
      chk("in_service", int'(in_service), int'(m_phase == PH_SVC));
      chk("pending", int'(pending), int'(m_pend));
      chk("lock_alarm", int'(rupt_lock_alarm), int'(m_alarm));
      chk("vector_hold", int'(rupt_vector), VBASE + 4 * last_idx);
      chk("index_hold", int'(rupt_index), last_idx);
    end
  end

  initial begin
    bit [9:0] rq;
    reset = 1'b1; rupt_req = '0; inst_boundary = 1'b0; inhint = 1'b0;
    extend_pending = 1'b0; resume = 1'b0;
    model_step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Single request on bit 3
    cyc(1'b0, 10'b00_0000_1000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    do_resume();
    idle(3);

    // Simultaneous edges on bits 7 and 2
    cyc(1'b0, 10'b00_1000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    do_resume();
    idle(5);
    do_resume();
    idle(3);

    // inhint holds off bit 0, then grant once released
    cyc(1'b0, 10'b00_0000_0001, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    do_resume();
    idle(2);

    // New edge on bit 5 during service
    cyc(1'b0, 10'b00_0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 10'b00_0010_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    do_resume();
    idle(4);
    do_resume();
    idle(2);

    // Resume ignored in IDLE, then lock alarm with no resume
    do_resume();
    cyc(1'b0, 10'b10_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(14);
    do_resume();
    idle(3);
    cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset during service with a request held high through release
    cyc(1'b0, 10'b00_0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 10'b00_0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'b00_0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 10'b00_0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 10'b00_0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rq = '0;
      for (int b = 0; b < 10; b++) rq[b] = ($urandom_range(0, 11) == 0);
      cyc(($urandom_range(0, 499) == 0), rq,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    // Drain: no boundaries, keep resuming so nothing new is granted
    for (int k = 0; k < 8; k++) cyc(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rupt_priority_controller.md
RUPT_PRIORITY_CONTROLLER -- requirements
Module: rupt_priority_controller

Interface
REQ-001 SHALL have parameter LOCK_LIMIT, default 4096, cycles in SERVICE before the rupt-lock alarm fires (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rupt_req  input  10  interrupt request lines; bit 0 = T6RUPT (highest priority) through bit 9 = HANDRUPT (lowest priority).
REQ-005 SHALL have port inst_boundary  input  1  high when the CPU is at an instruction boundary and can accept an interrupt.
REQ-006 SHALL have port inhint  input  1  interrupts inhibited (INHINT in effect).
REQ-007 SHALL have port extend_pending  input  1  EXTEND prefix pending; blocks interrupt take.
REQ-008 SHALL have port resume  input  1  one-cycle pulse; RESUME instruction executed.
REQ-009 SHALL have port rupt_take  output  1  one-cycle pulse; CPU loads rupt_vector into Z.
REQ-010 SHALL have port rupt_vector  output  12  interrupt vector address.
REQ-011 SHALL have port rupt_index  output  4  index of the granted request.
REQ-012 SHALL have port in_service  output  1  high while an interrupt routine is running.
REQ-013 SHALL have port pending  output  10  latched pending requests.
REQ-014 SHALL have port rupt_lock_alarm  output  1  sticky alarm; interrupt routine exceeded LOCK_LIMIT.

Function
REQ-015 SHALL register rupt_req each cycle and set pending[i] in the cycle after a 0->1 transition is detected on rupt_req[i]; a held-high level SHALL NOT re-set pending[i].
REQ-016 SHALL implement states IDLE, TAKE and SERVICE.
REQ-017 IDLE: when inst_boundary=1, inhint=0, extend_pending=0 and pending!=0 in a cycle, SHALL latch i = the lowest set pending index and move to TAKE on that clock edge.
REQ-018 TAKE: SHALL hold rupt_take=1 for exactly one cycle, clear pending[i] and move to SERVICE; rupt_take SHALL be high in the cycle after the grant condition was sampled.
REQ-019 SHALL compute rupt_vector = octal 4004 + 4*i (octal 4004..4050) and rupt_index = i; both SHALL be valid while rupt_take=1 and SHALL hold their value until the next grant.
REQ-020 SERVICE: in_service SHALL be 1 and no new grant SHALL occur; pending SHALL continue to accumulate new edges.
REQ-021 SERVICE: on resume=1 SHALL return to IDLE; in_service SHALL be 0 from the next cycle, and a new grant is allowed in that IDLE cycle at the earliest.
REQ-022 resume in IDLE or TAKE SHALL be ignored.
REQ-023 If a new edge on rupt_req[i] is detected in the same cycle as pending[i] is cleared in TAKE, set SHALL win and pending[i] SHALL remain 1.
REQ-024 A 16-bit lock counter SHALL clear on entry to SERVICE and increment each cycle spent in SERVICE, saturating at LOCK_LIMIT.
REQ-025 When the lock counter reaches LOCK_LIMIT, rupt_lock_alarm SHALL be set and SHALL remain 1 until reset, regardless of resume.
REQ-026 inhint and extend_pending SHALL only gate the IDLE->TAKE transition; they SHALL NOT affect TAKE or SERVICE.

Reset
REQ-027 While reset=1, state SHALL be IDLE, and pending, the registered rupt_req, the lock counter, rupt_take, in_service and rupt_lock_alarm SHALL all be 0; rupt_vector SHALL be octal 4004 and rupt_index SHALL be 0.
REQ-028 Reset asserted in TAKE or SERVICE SHALL abort the interrupt immediately; no rupt_take pulse SHALL be produced after reset release until a new edge arrives.
REQ-029 rupt_req already high at reset release SHALL NOT create a pending bit.

Verification
REQ-030 Pulse rupt_req[3] with inst_boundary=1, inhint=0 -> rupt_take one cycle, rupt_vector=octal 4020, rupt_index=3, in_service=1 until resume, pending[3]=0.
REQ-031 Edges on bits 7 and 2 in the same cycle -> bit 2 granted first (vector octal 4014); after resume, bit 7 granted (vector octal 4040).
REQ-032 inhint=1 with pending[0] set -> no rupt_take; drop inhint -> grant at the next inst_boundary with vector octal 4004.
REQ-033 New edge on bit 5 while in SERVICE -> pending[5]=1 and no grant; resume -> grant of bit 5 after returning to IDLE.
REQ-034 LOCK_LIMIT=8, no resume -> rupt_lock_alarm=1 after 8 SERVICE cycles; it stays 1 after resume, and reset clears it.
REQ-035 Assert reset during SERVICE -> in_service=0 and pending=0 at once; rupt_req held high through release -> no grant.
